kbd_cmd_uart_tx: RTL and testbench

Reverse path of the keyboard command decoder. Takes single-cycle player command strobes (D, E, B, F, R) and encodes each one back to its uppercase ASCII character. Characters are buffered in a small FIFO and sent out as 8N1 UART frames. This gives the host terminal an echo/status stream of every accepted command.

---
 rtl/kbd_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/kbd_cmd_uart_tx.sv | 133 +++++++++++++
 tb/tb_kbd_cmd_uart_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared command-character encoding and UART transmitter state encoding
// for the keyboard command path.
package kbd_pkg;

    localparam logic [7:0] CHAR_D = 8'h44;
    localparam logic [7:0] CHAR_E = 8'h45;
    localparam logic [7:0] CHAR_B = 8'h42;
    localparam logic [7:0] CHAR_F = 8'h46;
    localparam logic [7:0] CHAR_R = 8'h52;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; occupancy counter
// one bit wider than the pointers separates full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_cmd_uart_tx.sv
// Encodes player command strobes to ASCII, queues them and transmits each
// as an 8N1 UART frame with a registered tx line.
module kbd_cmd_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_d,
    input  logic cmd_e,
    input  logic cmd_b,
    input  logic cmd_f,
    input  logic cmd_r,
    output logic tx,
    output logic busy,
    output logic overflow
);

    import kbd_pkg::*;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    tx_state_t   state;
    logic [15:0] baud;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [7:0]  sr;
    logic        strobe;
    logic [7:0]  char_code;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    always_comb begin
        strobe = cmd_r | cmd_e | cmd_d | cmd_b | cmd_f;
        if (cmd_r) begin
            char_code = CHAR_R;
        end else if (cmd_e) begin
            char_code = CHAR_E;
        end else if (cmd_d) begin
            char_code = CHAR_D;
        end else if (cmd_b) begin
            char_code = CHAR_B;
        end else begin
            char_code = CHAR_F;
        end
        // push judged against the pre-pop full flag, so a full FIFO always drops
        fifo_push = strobe && !fifo_full;
        fifo_pop  = (state == IDLE) && !fifo_empty;
        busy      = (state != IDLE) || !fifo_empty;
        idx_next  = idx + 3'd1;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (char_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // tx is loaded with the value of the state being entered, keeping it registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            sr       <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (strobe && fifo_full) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        sr    <= fifo_dout;
                        state <= START;
                        baud  <= '0;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        state <= DATA;
                        baud  <= '0;
                        idx   <= '0;
                        tx    <= sr[0];
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            idx <= idx_next;
                            tx  <= sr[idx_next];
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        state <= IDLE;
                        baud  <= '0;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_cmd_uart_tx.sv
// Directed bench for kbd_cmd_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_kbd_cmd_uart_tx;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_d = 1'b0;
    logic cmd_e = 1'b0;
    logic cmd_b = 1'b0;
    logic cmd_f = 1'b0;
    logic cmd_r = 1'b0;
    logic tx;
    logic busy;
    logic overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    kbd_cmd_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_d    (cmd_d),
        .cmd_e    (cmd_e),
        .cmd_b    (cmd_b),
        .cmd_f    (cmd_f),
        .cmd_r    (cmd_r),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_cmds(input logic [4:0] v);
        {cmd_r, cmd_e, cmd_d, cmd_b, cmd_f} = v;
    endtask

    // Called in the cycle 5 after a start bit began; samples mid-bit and
    // returns in the first stop-bit cycle plus one.
    task automatic rx_bits(output logic [7:0] data, output logic stop_bit);
        data = '0;
        for (int i = 0; i < 8; i++) begin
            data[i] = tx;
            repeat (CLK_DIV) step();
        end
        stop_bit = tx;
    endtask

    task automatic rx_frame(input int budget, output logic [7:0] data, output int start_cyc,
                            output logic stop_bit, output bit timed_out);
        int n;
        n = 0;
        data = '0;
        stop_bit = 1'b0;
        timed_out = 1'b0;
        start_cyc = -1;
        while (tx !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        if (tx !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        start_cyc = cyc;
        repeat (CLK_DIV + 1) step();
        rx_bits(data, stop_bit);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: tx=%b busy=%b overflow=%b expected 1 0 0",
                         c, tx, busy, overflow);
            end
            step();
        end
    endtask

    task automatic test_single();
        logic [7:0] ch;
        logic       exp_tx;
        logic       exp_busy;
        int         rel;
        ch = 8'h46;
        set_cmds(5'b00001);
        for (int c = 0; c <= 45; c++) begin
            rel = c - 2;
            if (rel < 0)        exp_tx = 1'b1;
            else if (rel < 4)   exp_tx = 1'b0;
            else if (rel < 36)  exp_tx = ch[(rel - 4) / 4];
            else                exp_tx = 1'b1;
            exp_busy = (c >= 1 && c <= 41);
            checks++;
            if (tx !== exp_tx) begin
                failures++;
                $display("FAIL single_tx cycle %0d: tx=%b expected %b", c, tx, exp_tx);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL single_busy cycle %0d: busy=%b expected %b", c, busy, exp_busy);
            end
            step();
            set_cmds(5'b00000);
        end
    endtask

    task automatic test_priority();
        logic [7:0] data;
        logic       stop_bit;
        int         s;
        bit         to;
        bit         extra;
        apply_reset();
        set_cmds(5'b10101);
        step();
        set_cmds(5'b00000);
        rx_frame(100, data, s, stop_bit, to);
        checks++;
        if (to || data !== 8'h52 || stop_bit !== 1'b1) begin
            failures++;
            $display("FAIL priority_frame: data=%h stop=%b timeout=%0d expected 52 1 0",
                     data, stop_bit, to);
        end
        extra = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (tx !== 1'b1) extra = 1'b1;
            step();
        end
        checks++;
        if (extra || overflow !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL priority_single: extra_frame=%b overflow=%b busy=%b expected 0 0 0",
                     extra, overflow, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        logic [7:0] d2;
        logic       st1;
        logic       st2;
        int         s1;
        int         s2;
        int         c0;
        bit         to1;
        bit         to2;
        apply_reset();
        c0 = cyc;
        set_cmds(5'b01000);
        step();
        set_cmds(5'b00010);
        step();
        set_cmds(5'b00000);
        rx_frame(100, d1, s1, st1, to1);
        rx_frame(100, d2, s2, st2, to2);
        checks++;
        if (to1 || s1 - c0 !== 2) begin
            failures++;
            $display("FAIL b2b_first_start: offset=%0d timeout=%0d expected 2 0", s1 - c0, to1);
        end
        checks++;
        if (d1 !== 8'h45 || st1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_data: data=%h stop=%b expected 45 1", d1, st1);
        end
        checks++;
        if (to2 || d2 !== 8'h42 || st2 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_data: data=%h stop=%b timeout=%0d expected 42 1 0",
                     d2, st2, to2);
        end
        checks++;
        if (s2 - s1 !== 41) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles expected 41", s2 - s1);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] seq [6];
        logic [7:0] exp_ch [5];
        logic [7:0] data;
        logic       stop_bit;
        int         s;
        bit         to;
        bit         extra;
        seq[0] = 5'b00100; seq[1] = 5'b01000; seq[2] = 5'b00010;
        seq[3] = 5'b00001; seq[4] = 5'b10000; seq[5] = 5'b00100;
        exp_ch[0] = 8'h44; exp_ch[1] = 8'h45; exp_ch[2] = 8'h42;
        exp_ch[3] = 8'h46; exp_ch[4] = 8'h52;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            set_cmds(seq[c]);
            if (c == 2) begin
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_first_start: tx=%b expected 0", tx);
                end
            end
            if (c == 5) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_early: overflow=%b expected 0", overflow);
                end
            end
            step();
        end
        set_cmds(5'b00000);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: overflow=%b expected 1", overflow);
        end
        step();
        rx_bits(data, stop_bit);
        checks++;
        if (data !== exp_ch[0] || stop_bit !== 1'b1) begin
            failures++;
            $display("FAIL ovf_frame0: data=%h stop=%b expected %h 1", data, stop_bit, exp_ch[0]);
        end
        for (int f = 1; f < 5; f++) begin
            rx_frame(100, data, s, stop_bit, to);
            checks++;
            if (to || data !== exp_ch[f] || stop_bit !== 1'b1) begin
                failures++;
                $display("FAIL ovf_frame%0d: data=%h stop=%b timeout=%0d expected %h 1 0",
                         f, data, stop_bit, to, exp_ch[f]);
            end
        end
        repeat (CLK_DIV) step();
        extra = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (tx !== 1'b1) extra = 1'b1;
            step();
        end
        checks++;
        if (extra || busy !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained: extra_frame=%b busy=%b overflow=%b expected 0 0 1",
                     extra, busy, overflow);
        end
        apply_reset();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_cleared: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int  n;
        bit  bad;
        apply_reset();
        set_cmds(5'b00100);
        step();
        set_cmds(5'b00000);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL midreset_start: tx=%b expected 0 within budget", tx);
        end
        repeat (CLK_DIV + 6) step();
        checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL midreset_in_data: busy=%b tx=%b expected 1 0", busy, tx);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: tx=%b busy=%b expected 1 0", tx, busy);
        end
        bad = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midreset_quiet: activity=%b expected 0", bad);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
